// File: rtl/snake_dir_queue_pkg.sv
// Shared direction and button codes for the snake direction queue and the movement stage.
package snake_dir_queue_pkg;

    localparam int BITS_PER_DIR_DEFAULT = 2;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    // Bit positions of the buttons inside the packed level/pulse vectors.
    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_CENTER = 4;
    localparam int NUM_BTNS   = 5;

endpackage

// File: rtl/snake_dir_queue_rise_detect.sv
// Registered rising-edge detector: Pulse is high for one cycle, the cycle after In rises.
module rise_detect (
    input  logic Clock,
    input  logic Reset,
    input  logic In,
    output logic Pulse
);

    logic prev;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            prev  <= 1'b0;
            Pulse <= 1'b0;
        end else begin
            prev  <= In;
            Pulse <= In & ~prev;
        end
    end

endmodule

// File: rtl/snake_dir_queue.sv
// Turns debounced button levels into a tick-paced stream of snake directions,
// buffering turns in a small FIFO and handling pause.
module snake_dir_queue
    import snake_dir_queue_pkg::*;
#(
    parameter int QUEUE_DEPTH  = 2,
    parameter int BITS_PER_DIR = 2
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Left,
    input  logic                          Right,
    input  logic                          Up,
    input  logic                          Down,
    input  logic                          Center,
    input  logic                          GameTick,
    output logic [BITS_PER_DIR-1:0]       Dir,
    output logic                          Step,
    output logic                          Paused,
    output logic [$clog2(QUEUE_DEPTH):0]  QueueCount
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    logic [NUM_BTNS-1:0]     levels;
    logic [NUM_BTNS-1:0]     pulses;
    logic [BITS_PER_DIR-1:0] entries [QUEUE_DEPTH];
    logic [PW-1:0]           head;
    logic [PW-1:0]           tail;

    logic                    cand_valid;
    logic [BITS_PER_DIR-1:0] cand;
    logic [BITS_PER_DIR-1:0] ref_dir;
    logic                    pop;
    logic                    push;
    logic                    room;

    assign levels[BTN_UP]     = Up;
    assign levels[BTN_DOWN]   = Down;
    assign levels[BTN_LEFT]   = Left;
    assign levels[BTN_RIGHT]  = Right;
    assign levels[BTN_CENTER] = Center;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_rise
        rise_detect u_rise (
            .Clock (Clock),
            .Reset (Reset),
            .In    (levels[i]),
            .Pulse (pulses[i])
        );
    end

    always_comb begin
        cand_valid = 1'b1;
        cand       = '0;
        if (pulses[BTN_UP])         cand = BITS_PER_DIR'(DIR_UP);
        else if (pulses[BTN_DOWN])  cand = BITS_PER_DIR'(DIR_DOWN);
        else if (pulses[BTN_LEFT])  cand = BITS_PER_DIR'(DIR_LEFT);
        else if (pulses[BTN_RIGHT]) cand = BITS_PER_DIR'(DIR_RIGHT);
        else                        cand_valid = 1'b0;

        // Reference is the newest entry before any same-cycle pop.
        ref_dir = (QueueCount != '0) ? entries[tail - PW'(1)] : Dir;

        pop  = GameTick & ~Paused & (QueueCount != '0);
        room = (QueueCount < CW'(QUEUE_DEPTH)) | pop;
        push = cand_valid & ~pulses[BTN_CENTER] & ~Paused & room
             & (cand != ref_dir) & (cand != (ref_dir ^ BITS_PER_DIR'(1)));
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Dir        <= BITS_PER_DIR'(DIR_RIGHT);
            Step       <= 1'b0;
            Paused     <= 1'b0;
            QueueCount <= '0;
            head       <= '0;
            tail       <= '0;
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            Step <= GameTick & ~Paused;

            if (pop) begin
                Dir  <= entries[head];
                head <= head + PW'(1);
            end

            if (push) begin
                entries[tail] <= cand;
                tail          <= tail + PW'(1);
            end

            case ({push, pop})
                2'b10:   QueueCount <= QueueCount + CW'(1);
                2'b01:   QueueCount <= QueueCount - CW'(1);
                default: QueueCount <= QueueCount;
            endcase

            // Entering pause overrides any pointer/count update above.
            if (pulses[BTN_CENTER]) begin
                Paused <= ~Paused;
                if (!Paused) begin
                    head       <= '0;
                    tail       <= '0;
                    QueueCount <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_snake_dir_queue.sv
// Self-checking bench for snake_dir_queue: queue-based reference model plus directed literal checks.
module tb_snake_dir_queue;

    localparam int DEPTH = 2;

    logic       clk;
    logic       rst;
    logic       up, down, left, right, center, tick;
    logic [1:0] dir;
    logic       step;
    logic       paused;
    logic [1:0] qcount;

    int total_checks;
    int passed_checks;

    // reference model state
    int         mdir;
    int         mq[$];
    bit         mstep;
    bit         mpaused;
    logic [4:0] mprev;
    logic [4:0] mev;

    snake_dir_queue #(.QUEUE_DEPTH(DEPTH), .BITS_PER_DIR(2)) dut (
        .Clock      (clk),
        .Reset      (rst),
        .Left       (left),
        .Right      (right),
        .Up         (up),
        .Down       (down),
        .Center     (center),
        .GameTick   (tick),
        .Dir        (dir),
        .Step       (step),
        .Paused     (paused),
        .QueueCount (qcount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        total_checks++;
        if (act == exp) passed_checks++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: buttons bit0..4 = up, down, left, right, center; events lag levels by one cycle.
    always @(posedge clk or posedge rst) begin
        logic [4:0] lv;
        int  cand;
        int  refd;
        bit  do_pop;
        if (rst) begin
            mdir = 3;
            mq.delete();
            mstep = 0;
            mpaused = 0;
            mprev = '0;
            mev = '0;
        end else begin
            lv = {center, right, left, down, up};
            cand = -1;
            for (int b = 3; b >= 0; b--) if (mev[b]) cand = b;
            refd = (mq.size() > 0) ? mq[$] : mdir;
            do_pop = tick && !mpaused && mq.size() > 0;
            mstep = tick && !mpaused;
            if (do_pop) mdir = mq.pop_front();
            if (!mev[4] && cand >= 0 && !mpaused && mq.size() < DEPTH &&
                cand != refd && cand != (refd ^ 1))
                mq.push_back(cand);
            if (mev[4]) begin
                if (!mpaused) mq.delete();
                mpaused = !mpaused;
            end
            mev = lv & ~mprev;
            mprev = lv;
        end
    end

    always @(negedge clk) begin
        check("dir_vs_model", int'(dir), mdir);
        check("step_vs_model", int'(step), int'(mstep));
        check("paused_vs_model", int'(paused), int'(mpaused));
        check("count_vs_model", int'(qcount), mq.size());
    end

    task automatic drive(input logic u, input logic d, input logic l,
                         input logic r, input logic c, input logic t);
        up = u; down = d; left = l; right = r; center = c; tick = t;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        total_checks = 0;
        passed_checks = 0;
        rst = 1'b1;
        up = 0; down = 0; left = 0; right = 0; center = 0; tick = 0;
        @(negedge clk);
        check("reset_dir", int'(dir), 3);
        check("reset_step", int'(step), 0);
        check("reset_paused", int'(paused), 0);
        check("reset_count", int'(qcount), 0);
        #2 rst = 1'b0;
        @(negedge clk);

        // idle ticks keep RIGHT
        repeat (3) begin
            drive(0, 0, 0, 0, 0, 1);
            check("t1_step", int'(step), 1);
            check("t1_dir", int'(dir), 3);
        end
        idle(1);
        check("t1_step_low", int'(step), 0);

        // two turns buffered before a tick
        drive(1, 0, 0, 0, 0, 0); idle(1);
        drive(0, 0, 1, 0, 0, 0); idle(1);
        check("t2_count2", int'(qcount), 2);
        drive(0, 0, 0, 0, 0, 1);
        check("t2_dir_up", int'(dir), 0);
        check("t2_count1", int'(qcount), 1);
        drive(0, 0, 0, 0, 0, 1);
        check("t2_dir_left", int'(dir), 2);
        check("t2_count0", int'(qcount), 0);

        // reversal and duplicate rejection
        do_reset();
        drive(0, 0, 1, 0, 0, 0); idle(1);
        check("t3_left_rej", int'(qcount), 0);
        drive(0, 0, 0, 1, 0, 0); idle(1);
        check("t3_right_rej", int'(qcount), 0);
        drive(0, 1, 0, 0, 0, 0); idle(1);
        check("t3_down_acc", int'(qcount), 1);
        drive(0, 0, 0, 0, 0, 1);
        check("t3_dir_down", int'(dir), 1);

        // full queue, then push alongside a pop
        do_reset();
        drive(1, 0, 0, 0, 0, 0); idle(1);
        drive(0, 0, 1, 0, 0, 0); idle(1);
        drive(0, 1, 0, 0, 0, 0); idle(1);
        check("t4_full_drop", int'(qcount), 2);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        check("t4_dir_up", int'(dir), 0);
        check("t4_count_hold", int'(qcount), 2);

        // pause flushes, ticks ignored, resume keeps Dir
        drive(0, 0, 0, 0, 0, 1);
        check("t5_dir_left", int'(dir), 2);
        check("t5_count1", int'(qcount), 1);
        drive(0, 0, 0, 0, 1, 0); idle(1);
        check("t5_paused", int'(paused), 1);
        check("t5_flushed", int'(qcount), 0);
        repeat (5) begin
            drive(0, 0, 0, 0, 0, 1);
            check("t5_no_step", int'(step), 0);
        end
        drive(0, 0, 0, 0, 1, 0); idle(1);
        check("t5_unpaused", int'(paused), 0);
        drive(0, 0, 0, 0, 0, 1);
        check("t5_step", int'(step), 1);
        check("t5_dir_kept", int'(dir), 2);

        // simultaneous Up/Right, long hold, reset mid-hold
        do_reset();
        drive(1, 0, 0, 1, 0, 0);
        idle(1);
        check("t6_up_only", int'(qcount), 1);
        drive(0, 0, 0, 0, 0, 1);
        check("t6_dir_up", int'(dir), 0);
        drive(0, 0, 1, 0, 0, 0); idle(1);
        drive(0, 0, 0, 0, 0, 1);
        check("t6_dir_left", int'(dir), 2);
        repeat (100) drive(1, 0, 0, 0, 0, 0);
        check("t6_hold_once", int'(qcount), 1);
        drive(1, 0, 0, 0, 0, 1);
        check("t6_hold_pop", int'(dir), 0);
        check("t6_hold_step", int'(step), 1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_dir", int'(dir), 3);
        check("t6_rst_step", int'(step), 0);
        check("t6_rst_paused", int'(paused), 0);
        check("t6_rst_count", int'(qcount), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        repeat (3) drive(1, 0, 0, 0, 0, 0);
        check("t6_post_rst_event", int'(qcount), 1);
        idle(2);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
